// File: rtl/reversal_controller.sv
// Purpose: loads a message of up to 2^ADDR_W bytes into message memory and replays it back-to-front through the bit-reverse unit.
// Latency: one byte per cycle in LOAD; each output byte takes RD_ISSUE + RD_WAIT + OUT (3 cycles at default latencies).
// Backpressure: in_ready only in LOAD; out_byte is held stable while out_valid is high and out_ready is low.
module reversal_controller #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int REV_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rev_in,
    input  logic [DATA_W-1:0] rev_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_byte,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, OUT, DONE} state_t;

    // Longest message the memory can hold; longer requests are clamped to it.
    localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);
    // Remaining read-path cycles after the issue edge.
    localparam logic [3:0]      WAIT_INIT = 4'(MEM_LAT + REV_LAT - 1);

    logic              rst_meta_q, rst_sync_q;
    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] out_byte_q, out_byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Reset synchronizer: asserts asynchronously, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            wait_q     <= '0;
            out_byte_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
            out_byte_q <= out_byte_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state and output decode; mem_addr keeps its last value unless a state drives it.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        wait_d     = wait_q;
        out_byte_d = out_byte_q;
        addr_d     = addr_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        rev_in     = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    len_d   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
                    state_d = (msg_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    addr_d    = cnt_q[ADDR_W-1:0];
                    mem_wdata = in_byte;
                    cnt_d     = cnt_q + ONE;
                    // Last byte written: start reading from its address.
                    if (cnt_q == len_q - ONE) begin
                        ptr_d   = cnt_q[ADDR_W-1:0];
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                addr_d  = ptr_q;
                wait_d  = WAIT_INIT;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rev_in = mem_rdata;
                if (wait_q <= 4'd1) begin
                    out_byte_d = rev_out;
                    state_d    = OUT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Test for the lowest address before decrementing so ptr never wraps.
                    if (ptr_q == '0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q - 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr = addr_d;
    assign out_byte = out_byte_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reversal_controller.sv
// Purpose: directed and randomized checks of reversal_controller against a queue-based reference of the reversed message.
// Latency: message memory modelled with one-cycle synchronous read; bit-reverse stage follows rev_in.
// Backpressure: bench drives in_valid gaps and out_ready stalls.
module tb_reversal_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] msg_len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = '0;
    logic       in_ready;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] rev_in;
    logic [7:0] rev_out;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [7:0] mem [16];
    logic [7:0] preset [$];

    reversal_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .msg_len(msg_len),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rev_in(rev_in), .rev_out(rev_out),
        .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Message memory: write on the handshake edge, registered read.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Bit-reverse stage.
    always_comb begin
        rev_out = '0;
        for (int b = 0; b < 8; b++) rev_out[b] = rev_in[7-b];
    end

    // Reference bit reversal built from masks, independent of the unit model above.
    function automatic logic [7:0] ref_rev(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) if (x[i]) r = r | (8'h80 >> i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rev_in"}, rev_in, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_byte"}, out_byte, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_msg(input int len_in, input int stall, input bit gaps,
                           input bit abort, input bit start_on_done);
        int eff, i, k, guard, stall_left, base;
        bit prev_v, prev_hs;
        logic [7:0] b;
        logic [7:0] din [$];
        eff  = (len_in > 16) ? 16 : len_in;
        base = wr_cnt;
        @(negedge clk);
        start   = 1'b1;
        msg_len = 5'(len_in);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_rise", busy, 1);
        if (eff == 0) begin
            chk("len0_done", done, 1);
            chk("len0_valid", out_valid, 0);
            chk("len0_we", mem_we, 0);
            @(negedge clk);
            #1;
            chk("len0_idle", busy, 0);
            chk("len0_done_pulse", done, 0);
            chk("len0_writes", wr_cnt - base, 0);
            return;
        end

        // Load phase.
        i = 0;
        guard = 0;
        while (i < eff && guard < 100) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid) begin
                if (preset.size() > 0) b = preset.pop_front();
                else b = 8'($urandom);
                in_byte = b;
            end else begin
                in_byte = 8'($urandom);
            end
            #1;
            if (in_valid) begin
                chk("in_ready", in_ready, 1);
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, i);
                chk("wr_data", mem_wdata, b);
                din.push_back(b);
                i++;
            end else begin
                chk("gap_we", mem_we, 0);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 100) chk("load_timeout", i, eff);

        // Output phase.
        k = 0;
        guard = 0;
        stall_left = stall;
        prev_v = 1'b0;
        prev_hs = 1'b0;
        while (k < eff && guard < 1000) begin
            out_ready = (stall_left == 0);
            #1;
            if (prev_v && !prev_hs) chk("valid_hold", out_valid, 1);
            chk("rd_we", mem_we, 0);
            chk("rd_in_ready", in_ready, 0);
            if (out_valid) begin
                chk("out_byte", out_byte, ref_rev(din[eff-1-k]));
                if (abort) begin
                    out_ready = 1'b0;
                    #2 reset_n = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    repeat (2) @(negedge clk);
                    reset_n = 1'b1;
                    repeat (4) @(negedge clk);
                    return;
                end
                if (out_ready) begin
                    k++;
                    stall_left = stall;
                end else begin
                    stall_left--;
                end
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (guard >= 1000) chk("out_timeout", k, eff);
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", out_valid, 0);
        chk("writes", wr_cnt - base, eff);
        if (start_on_done) begin
            start   = 1'b1;
            msg_len = 5'd1;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        repeat (4) begin
            @(negedge clk);
            start     = 1'($urandom);
            msg_len   = 5'($urandom);
            in_valid  = 1'($urandom);
            in_byte   = 8'($urandom);
            out_ready = 1'($urandom);
            #1;
            chk_all_zero("reset");
        end
        @(negedge clk);
        start = 1'b0; msg_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk_all_zero("post_reset");

        run_msg(1, 0, 1'b0, 1'b0, 1'b0);

        preset = '{8'h01, 8'h80};
        run_msg(2, 0, 1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 16; v++) preset.push_back(8'(v));
        run_msg(16, 0, 1'b0, 1'b0, 1'b0);

        run_msg(3, 5, 1'b1, 1'b0, 1'b0);
        run_msg(0, 0, 1'b0, 1'b0, 1'b0);
        run_msg(17, 1, 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_msg($urandom_range(1, 16), $urandom_range(0, 3), 1'($urandom), 1'b0, 1'b0);

        run_msg(4, 0, 1'b0, 1'b1, 1'b0);
        preset = '{8'hA5};
        run_msg(1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reversal_controller.md
# reversal_controller

Sequencer for the bit-reversal datapath. It accepts a message of up to 16 bytes over a valid/ready input stream and writes it into the message memory. It then reads the memory back in descending address order through the bit-reverse unit and emits the fully reversed message (byte order and bit order inverted) on a valid/ready output stream. It sits between the byte source and the message_mem/reverse_bits pair and owns both of their ports.

## Interface
- ADDR_W, 4, memory address width; max message length 2^ADDR_W bytes
- DATA_W, 8, byte width
- MEM_LAT, 1, cycles from mem_addr to valid mem_rdata
- REV_LAT, 1, cycles from rev_in to valid rev_out

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a transaction when idle
- msg_len  in  ADDR_W+1  byte count, sampled on accepted start; legal 0..2^ADDR_W
- in_valid  in  1  input byte valid
- in_byte  in  DATA_W  input byte
- in_ready  out  1  controller accepts in_byte this cycle
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- rev_in  out  DATA_W  byte to bit-reverse unit
- rev_out  in  DATA_W  reversed byte from unit
- out_valid  out  1  out_byte valid
- out_byte  out  DATA_W  reversed byte
- out_ready  in  1  consumer accepts out_byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, LOAD, RD_ISSUE, RD_WAIT, OUT, DONE.
- IDLE: when start=1, latch len=msg_len and set cnt=0.
  - If len=0, go to DONE.
  - If len>2^ADDR_W, clamp to 2^ADDR_W.
  - Otherwise go to LOAD.
  - start is ignored in all other states.
- LOAD: in_ready=1. On in_valid&&in_ready, drive mem_we=1, mem_addr=cnt[ADDR_W-1:0], mem_wdata=in_byte (combinational, same cycle), then cnt++. After the write with cnt==len-1, set ptr=len-1 and go to RD_ISSUE.
- RD_ISSUE: drive mem_addr=ptr, mem_we=0, then go to RD_WAIT with wait counter = MEM_LAT+REV_LAT-1.
- RD_WAIT: rev_in=mem_rdata (combinational pass-through). Count down. When the counter reaches 0, capture rev_out into the out_byte register and go to OUT.
- OUT: out_valid=1 and out_byte is held stable until out_valid&&out_ready. On that handshake:
  - if ptr==0, go to DONE;
  - otherwise ptr--, then go to RD_ISSUE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- mem_addr holds its last value when not in use. mem_we=0 outside LOAD handshakes.
- Arithmetic: cnt and len are ADDR_W+1 bits wide. ptr is ADDR_W bits wide; it never wraps because the ptr==0 exit is tested before decrement.

## Timing
- Reset (async assert, sync deassert internally) forces:
  - state=IDLE;
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, rev_in=0;
  - out_valid=0, out_byte=0, busy=0, done=0.
- Reset mid-transaction aborts it immediately; memory contents are undefined to the controller.
- busy rises the cycle after the accepted start.
- Load: one byte per cycle at full rate. A write lands on the clock edge of its handshake.
- Read latency per byte (defaults): RD_ISSUE edge + 1 wait cycle, so out_valid is asserted 2 cycles after RD_ISSUE entry.
- Throughput at the default latencies is one byte per 3 cycles with out_ready held high.
- out_valid never drops without a handshake. out_byte never changes while out_valid=1 and out_ready=0.
- done asserts the cycle after the final output handshake (or 1 cycle after start when len=0). busy falls together with the return to IDLE.
- start asserted in the same cycle as done is ignored.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs 0 and busy=0. Release, then pulse start with msg_len=1 -> busy=1 next cycle.
- Basic: msg_len=2, in bytes 0x01, 0x80 -> mem writes addr0=0x01, addr1=0x80. Outputs in order: 0x01 (rev of 0x80), then 0x80 (rev of 0x01). Then a single done pulse.
- Full length: msg_len=16, bytes 0x00..0x0F -> the 16 outputs are rev8(0x0F) down to rev8(0x00), i.e. 0xF0, 0x70, 0xB0, ..., 0x00. No address wrap; done after the 16th handshake.
- Backpressure: msg_len=3, out_ready low for 5 cycles on each byte -> out_byte stable while stalled, no byte lost or duplicated. Same with in_valid gaps during LOAD: writes occur only on handshakes.
- Edge lengths: msg_len=0 -> no mem_we and no out_valid; done 1 cycle after start. msg_len=17 -> behaves exactly as 16.
- Abort: assert reset_n=0 mid-OUT during a msg_len=4 run -> outputs reset asynchronously. A subsequent start with msg_len=1 and byte 0xA5 outputs 0xA5.
